// File: rtl/mealy_pkg.sv
// Shared defaults, table entry layout and the state legality check for the
// runtime-programmable Mealy machine.
package mealy_pkg;

    localparam int N_STATES_DEF = 4;
    localparam int IN_W_DEF     = 2;
    localparam int OUT_W_DEF    = 1;
    localparam int CNT_W_DEF    = 8;
    localparam int SW_DEF       = $clog2(N_STATES_DEF);

    // Entry layout at default widths; the table stores {nxt, o} in this order.
    typedef struct packed {
        logic [SW_DEF-1:0]    nxt;
        logic [OUT_W_DEF-1:0] o;
    } mealy_entry_t;

    function automatic logic legal_state(input int unsigned s, input int unsigned n);
        return s < n;
    endfunction

endpackage

// File: rtl/mealy_table.sv
// Flop-based transition table: one combinational read port, one synchronous
// write port, synchronous reset of every row to a self-loop with zero output.
module mealy_table
    import mealy_pkg::*;
#(
    parameter int N_STATES = N_STATES_DEF,
    parameter int IN_W     = IN_W_DEF,
    parameter int OUT_W    = OUT_W_DEF,
    parameter int SW       = $clog2(N_STATES)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SW-1:0]       rd_state_i,
    input  logic [IN_W-1:0]     rd_sym_i,
    output logic [SW+OUT_W-1:0] rd_data_o,
    input  logic                we_i,
    input  logic [SW-1:0]       wr_state_i,
    input  logic [IN_W-1:0]     wr_sym_i,
    input  logic [SW+OUT_W-1:0] wr_data_i
);

    localparam int N_SYM = 2 ** IN_W;

    logic [SW+OUT_W-1:0] tbl_q [N_STATES][N_SYM];

    // Rows beyond N_STATES do not exist; the top traps that case separately.
    always_comb begin
        rd_data_o = '0;
        if (legal_state(32'(rd_state_i), N_STATES))
            rd_data_o = tbl_q[rd_state_i][rd_sym_i];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < N_STATES; r++)
                for (int c = 0; c < N_SYM; c++)
                    tbl_q[r][c] <= {SW'(r), {OUT_W{1'b0}}};
        end else if (we_i) begin
            tbl_q[wr_state_i][wr_sym_i] <= wr_data_i;
        end
    end

endmodule

// File: rtl/mealy_prog.sv
// Runtime-programmable Mealy machine: current state, last output, step valid
// pulse, saturating step counter and sticky error around a programmable table.
module mealy_prog
    import mealy_pkg::*;
#(
    parameter int N_STATES = N_STATES_DEF,
    parameter int IN_W     = IN_W_DEF,
    parameter int OUT_W    = OUT_W_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    localparam int SW      = $clog2(N_STATES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IN_W-1:0]  sw_in,
    input  logic             ctrl_in,
    input  logic             load_in,
    input  logic [SW-1:0]    state_in,
    input  logic             cfg_we,
    input  logic [SW-1:0]    cfg_state,
    input  logic [IN_W-1:0]  cfg_sym,
    input  logic [SW-1:0]    cfg_next,
    input  logic [OUT_W-1:0] cfg_out,
    output logic [SW-1:0]    state,
    output logic [OUT_W-1:0] out,
    output logic             out_vld,
    output logic             err,
    output logic [CNT_W-1:0] step_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SW-1:0]       state_q;
    logic [OUT_W-1:0]    out_q;
    logic                vld_q, err_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SW+OUT_W-1:0] rd_data;
    logic [SW-1:0]       rd_nxt, preset_d;
    logic [OUT_W-1:0]    rd_o;
    logic                in_legal, cur_legal, nxt_legal, cfg_legal, wr_ok;

    assign {rd_nxt, rd_o} = rd_data;

    assign in_legal  = legal_state(32'(state_in), N_STATES);
    assign cur_legal = legal_state(32'(state_q), N_STATES);
    assign nxt_legal = legal_state(32'(rd_nxt), N_STATES);
    assign cfg_legal = legal_state(32'(cfg_state), N_STATES) &&
                       legal_state(32'(cfg_next), N_STATES);
    assign wr_ok     = cfg_we && cfg_legal;
    assign preset_d  = in_legal ? state_in : '0;
    assign cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    // Table write lands at the edge, so a same-cycle step reads the old entry.
    mealy_table #(
        .N_STATES (N_STATES),
        .IN_W     (IN_W),
        .OUT_W    (OUT_W),
        .SW       (SW)
    ) u_table (
        .clk        (clk),
        .reset      (reset),
        .rd_state_i (state_q),
        .rd_sym_i   (sw_in),
        .rd_data_o  (rd_data),
        .we_i       (wr_ok),
        .wr_state_i (cfg_state),
        .wr_sym_i   (cfg_sym),
        .wr_data_i  ({cfg_next, cfg_out})
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= preset_d;
            err_q   <= !in_legal;
            out_q   <= '0;
            vld_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            vld_q <= 1'b0;
            if (cfg_we && !cfg_legal)
                err_q <= 1'b1;
            if (load_in) begin
                state_q <= preset_d;
                cnt_q   <= '0;
                if (!in_legal)
                    err_q <= 1'b1;
            end else if (ctrl_in) begin
                if (cur_legal && nxt_legal) begin
                    state_q <= rd_nxt;
                    out_q   <= rd_o;
                    vld_q   <= 1'b1;
                    cnt_q   <= cnt_d;
                end else begin
                    // Corrupt state: hold position, blank the output, flag it.
                    out_q <= '0;
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign state    = state_q;
    assign out      = out_q;
    assign out_vld  = vld_q;
    assign err      = err_q;
    assign step_cnt = cnt_q;

endmodule

// File: tb/tb_mealy_prog.sv
// Bench for mealy_prog: directed table vectors on a 4-state instance, error and
// saturation cases on a 5-state/2-bit-counter instance, then a random run vs a model.
module tb_mealy_prog;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // 4-state, 8-bit counter instance
    logic       reset0, ctrl0, load0, we0, cout0;
    logic [1:0] sw0, st_in0, cst0, csym0, cnxt0;
    logic [1:0] state0;
    logic       out0, vld0, err0;
    logic [7:0] cnt0;

    // 5-state (3-bit state), 2-bit counter instance
    logic       reset1, ctrl1, load1, we1, cout1;
    logic [1:0] sw1, csym1;
    logic [2:0] st_in1, cst1, cnxt1;
    logic [2:0] state1;
    logic       out1, vld1, err1;
    logic [1:0] cnt1;

    mealy_prog #(.N_STATES(4), .IN_W(2), .OUT_W(1), .CNT_W(8)) dut0 (
        .clk(clk), .reset(reset0), .sw_in(sw0), .ctrl_in(ctrl0), .load_in(load0),
        .state_in(st_in0), .cfg_we(we0), .cfg_state(cst0), .cfg_sym(csym0),
        .cfg_next(cnxt0), .cfg_out(cout0), .state(state0), .out(out0),
        .out_vld(vld0), .err(err0), .step_cnt(cnt0)
    );

    mealy_prog #(.N_STATES(5), .IN_W(2), .OUT_W(1), .CNT_W(2)) dut1 (
        .clk(clk), .reset(reset1), .sw_in(sw1), .ctrl_in(ctrl1), .load_in(load1),
        .state_in(st_in1), .cfg_we(we1), .cfg_state(cst1), .cfg_sym(csym1),
        .cfg_next(cnxt1), .cfg_out(cout1), .state(state1), .out(out1),
        .out_vld(vld1), .err(err1), .step_cnt(cnt1)
    );

    typedef struct {
        logic [1:0] sw;
        int         es;
        int         eo;
        int         ec;
    } vec_t;

    int pn [4][4] = '{'{0, 2, 1, 2}, '{1, 0, 2, 2}, '{1, 3, 3, 3}, '{1, 0, 0, 2}};
    int po [4][4] = '{'{1, 0, 0, 0}, '{1, 1, 0, 0}, '{1, 1, 1, 0}, '{1, 0, 1, 1}};

    // Reference model state for the random phase
    int mn [4][4];
    int mo [4][4];
    int ms, mout, mv, mc, me;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk0(input string nm, input int s, input int o, input int v, input int c, input int e);
        chk({nm, ".state"}, 32'(state0), s);
        chk({nm, ".out"}, 32'(out0), o);
        chk({nm, ".vld"}, 32'(vld0), v);
        chk({nm, ".cnt"}, 32'(cnt0), c);
        chk({nm, ".err"}, 32'(err0), e);
    endtask

    task automatic chk1(input string nm, input int s, input int o, input int v, input int c, input int e);
        chk({nm, ".state"}, 32'(state1), s);
        chk({nm, ".out"}, 32'(out1), o);
        chk({nm, ".vld"}, 32'(vld1), v);
        chk({nm, ".cnt"}, 32'(cnt1), c);
        chk({nm, ".err"}, 32'(err1), e);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset(input int st);
        ms = st; me = 0; mout = 0; mv = 0; mc = 0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                mn[r][c] = r;
                mo[r][c] = 0;
            end
    endtask

    initial begin
        vec_t vt[5];
        vec_t sat[5];
        int   rn, ro;

        reset0 = 1; ctrl0 = 0; load0 = 0; we0 = 0; cout0 = 0;
        sw0 = 0; st_in0 = 2; cst0 = 0; csym0 = 0; cnxt0 = 0;
        reset1 = 1; ctrl1 = 0; load1 = 0; we1 = 0; cout1 = 0;
        sw1 = 0; st_in1 = 6; cst1 = 0; csym1 = 0; cnxt1 = 0;

        // ---- 4-state instance: reset preset and self-loop table ----
        tick;
        reset0 = 0;
        chk0("rst", 2, 0, 0, 0, 0);
        ctrl0 = 1;
        for (int k = 1; k <= 3; k++) begin
            sw0 = 2'($urandom);
            tick;
            chk0("selfloop", 2, 0, 1, k, 0);
        end
        ctrl0 = 0;
        tick;
        chk0("idle", 2, 0, 0, 3, 0);

        // Program the 4x4 table, then preset to state 0
        we0 = 1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                cst0 = 2'(r); csym0 = 2'(c); cnxt0 = 2'(pn[r][c]); cout0 = po[r][c][0];
                tick;
            end
        we0 = 0;
        chk0("prog_nostep", 2, 0, 0, 3, 0);
        load0 = 1; st_in0 = 0;
        tick;
        load0 = 0;
        chk0("load0", 0, 0, 0, 0, 0);

        vt[0] = '{2'd1, 2, 0, 1};
        vt[1] = '{2'd2, 3, 1, 2};
        vt[2] = '{2'd0, 1, 1, 3};
        vt[3] = '{2'd1, 0, 1, 4};
        vt[4] = '{2'd3, 2, 0, 5};
        ctrl0 = 1;
        for (int i = 0; i < 5; i++) begin
            sw0 = vt[i].sw;
            tick;
            chk0($sformatf("walk%0d", i), vt[i].es, vt[i].eo, 1, vt[i].ec, 0);
        end
        ctrl0 = 0;

        // Same-cycle write and step on one entry: step sees the old entry
        load0 = 1; st_in0 = 0;
        tick;
        load0 = 0;
        we0 = 1; cst0 = 0; csym0 = 1; cnxt0 = 3; cout0 = 1;
        ctrl0 = 1; sw0 = 1;
        tick;
        we0 = 0; ctrl0 = 0;
        chk0("rbw_old", 2, 0, 1, 1, 0);
        load0 = 1; st_in0 = 0;
        tick;
        load0 = 0;
        chk0("rbw_load", 0, 0, 0, 0, 0);
        ctrl0 = 1; sw0 = 1;
        tick;
        ctrl0 = 0;
        chk0("rbw_new", 3, 1, 1, 1, 0);

        // load beats ctrl; out holds
        load0 = 1; ctrl0 = 1; st_in0 = 1; sw0 = 0;
        tick;
        load0 = 0; ctrl0 = 0;
        chk0("load_pri", 1, 1, 0, 0, 0);

        // ---- 5-state instance: clamp, dropped writes, sticky err, saturation ----
        chk1("clamp_rst", 0, 0, 0, 0, 1);
        st_in1 = 2;
        tick;
        reset1 = 0;
        chk1("rst1", 2, 0, 0, 0, 0);
        we1 = 1; cst1 = 2; csym1 = 0; cnxt1 = 5; cout1 = 1;
        tick;
        we1 = 0;
        chk1("bad_next", 2, 0, 0, 0, 1);
        ctrl1 = 1; sw1 = 0;
        tick;
        ctrl1 = 0;
        chk1("tbl_kept", 2, 0, 1, 1, 1);
        reset1 = 1;
        tick;
        reset1 = 0;
        chk1("rst_clr", 2, 0, 0, 0, 0);
        we1 = 1; cst1 = 7; csym1 = 0; cnxt1 = 1;
        tick;
        we1 = 0;
        chk1("bad_row", 2, 0, 0, 0, 1);
        load1 = 1; st_in1 = 7;
        tick;
        chk1("load_clamp", 0, 0, 0, 0, 1);
        st_in1 = 2;
        tick;
        load1 = 0;
        chk1("load_sticky", 2, 0, 0, 0, 1);

        reset1 = 1;
        tick;
        reset1 = 0;
        we1 = 1; cst1 = 2; csym1 = 1; cnxt1 = 4; cout1 = 1;
        tick;
        we1 = 0;
        sat[0] = '{2'd1, 4, 1, 1};
        sat[1] = '{2'd0, 4, 0, 2};
        sat[2] = '{2'd0, 4, 0, 3};
        sat[3] = '{2'd2, 4, 0, 3};
        sat[4] = '{2'd3, 4, 0, 3};
        ctrl1 = 1;
        for (int i = 0; i < 5; i++) begin
            sw1 = sat[i].sw;
            tick;
            chk1($sformatf("sat%0d", i), sat[i].es, sat[i].eo, 1, sat[i].ec, 0);
        end
        reset1 = 1; st_in1 = 2;
        tick;
        reset1 = 0;
        chk1("mid_rst", 2, 0, 0, 0, 0);
        sw1 = 1;
        tick;
        ctrl1 = 0;
        chk1("selfloop_back", 2, 0, 1, 1, 0);

        // ---- random run on the 4-state instance against the model ----
        reset0 = 1; st_in0 = 2'($urandom);
        model_reset(int'(st_in0));
        tick;
        reset0 = 0;
        chk0("rand_rst", ms, mout, mv, mc, me);
        for (int i = 0; i < 400; i++) begin
            reset0 = ($urandom_range(0, 39) == 0);
            load0  = ($urandom_range(0, 7) == 0);
            ctrl0  = 1'($urandom);
            we0    = ($urandom_range(0, 2) == 0);
            sw0    = 2'($urandom); st_in0 = 2'($urandom);
            cst0   = 2'($urandom); csym0  = 2'($urandom);
            cnxt0  = 2'($urandom); cout0  = 1'($urandom);
            if (reset0) begin
                model_reset(int'(st_in0));
            end else begin
                rn = mn[ms][sw0];
                ro = mo[ms][sw0];
                mv = 0;
                if (we0) begin
                    mn[cst0][csym0] = int'(cnxt0);
                    mo[cst0][csym0] = int'(cout0);
                end
                if (load0) begin
                    ms = int'(st_in0);
                    mc = 0;
                end else if (ctrl0) begin
                    ms = rn; mout = ro; mv = 1;
                    mc = (mc < 255) ? mc + 1 : 255;
                end
            end
            tick;
            chk0($sformatf("rand%0d", i), ms, mout, mv, mc, me);
        end
        reset0 = 0; load0 = 0; ctrl0 = 0; we0 = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
